hazard_controller: RTL and testbench
====================================

// Module: hazard_controller
// PURPOSE
// - Sequences the 5-stage RV32I pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
// - Generates forwarding selects, load-use stalls and branch/jump flushes.
// - Freezes the whole pipeline while the data memory inserts wait states.
// - Keeps saturating stall/flush performance counters and a sticky memory-timeout error.
// PARAMETERS
// TIMEOUT  16  max WAIT cycles before a memory timeout is declared (>=2)
// CNT_W    32  width of the performance counters
// PORTS
// clk         in   1      clock, all state on rising edge
// reset       in   1      asynchronous, active-low reset
// Rs1D,Rs2D   in   5      source regs of the instruction in D
// Rs1E,Rs2E   in   5      source regs of the instruction in E
// RdE,RdM,RdW in   5      destination regs in E/M/W
// ResultSrcE  in   2      2'b01 = load in E
// RegWriteM   in   1      M writes the register file
// RegWriteW   in   1      W writes the register file
// PCSrcE      in   1      branch taken / jump in E
// MemReqM     in   1      load/store in M requests data memory
// MemReadyM   in   1      data memory completes the access this cycle
// CountClr    in   1      synchronous clear of both counters
// ForwardAE   out  2      00 RD1E, 01 ResultW, 10 ALUResultM
// ForwardBE   out  2      same encoding, for RD2E
// StallF,StallD,StallE,StallM,StallW  out 1  hold the corresponding pipeline register
// FlushD,FlushE  out  1   bubble into IF/ID, ID/EX
// MemTimeout  out  1      sticky timeout error
// StallCount  out  CNT_W  cycles with any Stall* asserted
// FlushCount  out  CNT_W  cycles with a PCSrcE flush
// BEHAVIOUR
// - Forwarding is combinational, per operand: 10 if RegWriteM && RdM!=0 && RdM==RsxE.
//   Otherwise 01 if RegWriteW && RdW!=0 && RdW==RsxE. Otherwise 00. M beats W.
// - lwStall = ResultSrcE==2'b01 && RdE!=0 && (Rs1D==RdE || Rs2D==RdE).
// - FSM (registered state): RUN, WAIT, ERROR. reset -> RUN.
//   RUN -> WAIT when MemReqM && !MemReadyM.
//   WAIT -> RUN when MemReadyM.
//   WAIT -> ERROR when !MemReadyM and wait_cnt == TIMEOUT-1.
//   ERROR holds until reset.
// - wait_cnt clears in RUN and counts +1 per WAIT cycle.
// - memStall = (RUN && MemReqM && !MemReadyM) || (WAIT && !MemReadyM) || ERROR. Combinational, zero latency.
// - Priority, highest first:
//   1. memStall: all five Stall*=1, FlushD=FlushE=0. PCSrcE is held in E and acted on after release.
//   2. PCSrcE: FlushD=1, FlushE=1, StallF=StallD=0. Wins over lwStall.
//   3. lwStall: StallF=StallD=1, FlushE=1.
//   4. Otherwise all Stall*/Flush* are 0.
// - StallE/StallM/StallW are asserted only by memStall.
// - MemTimeout = (state==ERROR). Registered, so it rises the cycle after the timeout edge.
// - Counters saturate at all-ones. CountClr wins over increment.
//   StallCount increments on any Stall*. FlushCount increments on a priority-2 cycle.
// - Reset values: state RUN, wait_cnt 0, counters 0, MemTimeout 0.
//   All stall/flush outputs are 0 while reset is low, regardless of inputs.
//   Forward* stay combinational (00 for zero inputs).
// - Reset asserted mid-WAIT returns to RUN immediately. A pending access is abandoned.
// STRUCTURE
// - hazard_pkg holds:
//   - typedef enum logic [1:0] {RUN, WAIT, ERROR} hz_state_t;
//   - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
//   - RESULT_SRC_MEM=2'b01.
// - Sub-module forward_unit (combinational, one per operand, instantiated twice).
// - FSM, wait counter and perf counters live in hazard_controller.
// TESTING
// 1. RdM=5, RegWriteM=1, Rs1E=5; also RdW=5, RegWriteW=1 -> ForwardAE=10.
//    Same with RdM=0 -> ForwardAE=01. Rd=0 never forwards.
// 2. ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly 1 cycle.
//    StallCount +1.
// 3. PCSrcE=1 with lwStall also true -> FlushD=FlushE=1, StallF=StallD=0.
//    FlushCount +1.
// 4. MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> all Stall*=1 for 3 cycles.
//    State returns to RUN. StallCount +3. PCSrcE=1 during the wait causes no flush until release.
// 5. MemReadyM=0 for TIMEOUT cycles -> ERROR, MemTimeout=1 sticky, stalls held.
//    reset low clears everything.
// 6. Preset StallCount near all-ones (CNT_W=4): saturates at 4'hF.
//    CountClr with a stall active -> 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state, forwarding and result-source encodings for the hazard controller.
package hazard_pkg;
  typedef enum logic [1:0] {RUN, WAIT, ERROR} hz_state_t;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
endpackage

// File: rtl/forward_unit.sv
// forward_unit: per-operand bypass select for the instruction in E; the M stage beats the W stage.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rsE,
  input  logic [4:0] rdM,
  input  logic [4:0] rdW,
  input  logic       regWriteM,
  input  logic       regWriteW,
  output logic [1:0] forward
);
  always_comb
    forward = (regWriteM && rdM != 5'd0 && rdM == rsE) ? FWD_MEM :
              (regWriteW && rdW != 5'd0 && rdW == rsE) ? FWD_WB : FWD_REG;
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: forwarding, load-use stall, branch flush and data-memory wait/timeout control
// for a 5-stage RV32I pipeline, plus saturating stall/flush performance counters.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             CountClr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushD,
  output logic             FlushE,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);
  localparam int WCW = $clog2(TIMEOUT);
  hz_state_t state, nextState;
  logic [WCW-1:0] waitCnt;
  logic lwStall, memStall;
  forward_unit fwdA (.rsE(Rs1E), .rdM(RdM), .rdW(RdW), .regWriteM(RegWriteM), .regWriteW(RegWriteW), .forward(ForwardAE));
  forward_unit fwdB (.rsE(Rs2E), .rdM(RdM), .rdW(RdW), .regWriteM(RegWriteM), .regWriteW(RegWriteW), .forward(ForwardBE));
  always_comb begin
    lwStall = ResultSrcE == RESULT_SRC_MEM && RdE != 5'd0 && (Rs1D == RdE || Rs2D == RdE);
    memStall = (state == RUN && MemReqM && !MemReadyM) || (state == WAIT && !MemReadyM) || state == ERROR;
    nextState = (state == ERROR) ? ERROR :
                (state == RUN) ? ((MemReqM && !MemReadyM) ? WAIT : RUN) :
                MemReadyM ? RUN :
                (waitCnt == WCW'(TIMEOUT - 1)) ? ERROR : WAIT;
    // A taken branch is held in E during a memory freeze and acted on after release.
    StallE = reset && memStall;
    StallM = StallE;
    StallW = StallE;
    StallF = reset && (memStall || (!PCSrcE && lwStall));
    StallD = StallF;
    FlushD = reset && !memStall && PCSrcE;
    FlushE = reset && !memStall && (PCSrcE || lwStall);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= RUN;
      waitCnt <= '0;
      MemTimeout <= 1'b0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      state <= nextState;
      waitCnt <= (state == WAIT) ? waitCnt + WCW'(1) : (state == RUN) ? '0 : waitCnt;
      MemTimeout <= nextState == ERROR;
      StallCount <= CountClr ? '0 : ((StallF || StallE) && !(&StallCount)) ? StallCount + CNT_W'(1) : StallCount;
      FlushCount <= CountClr ? '0 : (FlushD && !(&FlushCount)) ? FlushCount + CNT_W'(1) : FlushCount;
    end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: scenario tasks push expected outputs to a scoreboard when driving each cycle
// and pop/compare them mid-cycle, before the next rising edge.
module tb_hazard_controller;
  localparam int TIMEOUT = 5;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic [1:0] resSrc;
    logic rwM, rwW, pc, req, rdy, clr;
  } in_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic [4:0] st;
    logic [1:0] fl;
    logic to;
    logic [3:0] sc, fc;
  } obs_t;

  logic clk = 1'b0, reset = 1'b0;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM, CountClr;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MemTimeout;
  logic [CNT_W-1:0] StallCount, FlushCount;
  obs_t obs;
  obs_t sb[$];
  int tests = 0, fails = 0, expSc = 0, expFc = 0;

  hazard_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .CountClr(CountClr), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF),
    .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW), .FlushD(FlushD),
    .FlushE(FlushE), .MemTimeout(MemTimeout), .StallCount(StallCount), .FlushCount(FlushCount));

  always #5 clk = ~clk;

  assign obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
                MemTimeout, StallCount, FlushCount};

  task automatic apply(input in_t s);
    @(posedge clk);
    #1;
    Rs1D = s.rs1D; Rs2D = s.rs2D; Rs1E = s.rs1E; Rs2E = s.rs2E;
    RdE = s.rdE; RdM = s.rdM; RdW = s.rdW; ResultSrcE = s.resSrc;
    RegWriteM = s.rwM; RegWriteW = s.rwW; PCSrcE = s.pc;
    MemReqM = s.req; MemReadyM = s.rdy; CountClr = s.clr;
  endtask

  function automatic obs_t mk(logic [1:0] fa, logic [1:0] fb, logic [4:0] st, logic [1:0] fl, logic to);
    logic [3:0] sc, fc;
    sc = 4'(expSc);
    fc = 4'(expFc);
    mk = {fa, fb, st, fl, to, sc, fc};
  endfunction

  // Reference counter model: advance after the edge that follows a sampled cycle.
  task automatic account(input obs_t e, input logic clr);
    if (clr) begin
      expSc = 0;
      expFc = 0;
    end else begin
      if (|e.st) expSc = (expSc == 15) ? 15 : expSc + 1;
      if (e.fl[1]) expFc = (expFc == 15) ? 15 : expFc + 1;
    end
  endtask

  task automatic test_reset();
    in_t s;
    obs_t e;
    for (int k = 0; k < 2; k++) begin
      s = '0;
      if (k == 0) begin
        s.rdM = 5; s.rwM = 1; s.rs1E = 5; s.resSrc = 2'b01; s.rdE = 7; s.rs1D = 7;
        s.pc = 1; s.req = 1; s.rdy = 0;
      end
      apply(s);
      if (k == 1) reset = 1'b1;
      sb.push_back(mk(k == 0 ? 2'b10 : 2'b00, 2'b00, 5'b0, 2'b0, 1'b0));
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL reset k=%0d got %h want %h", k, obs, e); end
      account(e, s.clr);
    end
  endtask

  task automatic test_forward();
    in_t s;
    obs_t e;
    logic [1:0] fa, fb;
    for (int k = 0; k < 5; k++) begin
      s = '0;
      case (k)
        0: begin s.rdM = 5; s.rwM = 1; s.rs1E = 5; s.rdW = 5; s.rwW = 1; fa = 2'b10; fb = 2'b00; end
        1: begin s.rdM = 0; s.rwM = 1; s.rs1E = 5; s.rdW = 5; s.rwW = 1; fa = 2'b01; fb = 2'b00; end
        2: begin s.rwM = 1; s.rwW = 1; fa = 2'b00; fb = 2'b00; end
        3: begin s.rdM = 3; s.rwM = 1; s.rs1E = 3; s.rs2E = 9; s.rdW = 9; s.rwW = 1; fa = 2'b10; fb = 2'b01; end
        default: begin s.rdM = 5; s.rs1E = 5; s.rs2E = 5; s.rdW = 6; s.rwW = 1; fa = 2'b00; fb = 2'b00; end
      endcase
      apply(s);
      sb.push_back(mk(fa, fb, 5'b0, 2'b0, 1'b0));
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL forward k=%0d got %h want %h", k, obs, e); end
      account(e, s.clr);
    end
  endtask

  task automatic test_lw_stall();
    in_t s;
    obs_t e;
    for (int k = 0; k < 3; k++) begin
      s = '0;
      s.resSrc = 2'b01;
      s.rdE = (k == 2) ? 5'd0 : 5'd7;
      s.rs2D = (k == 0) ? 5'd7 : 5'd0;
      apply(s);
      sb.push_back(mk(2'b00, 2'b00, k == 0 ? 5'b11000 : 5'b0, k == 0 ? 2'b01 : 2'b00, 1'b0));
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL lw_stall k=%0d got %h want %h", k, obs, e); end
      account(e, s.clr);
    end
  endtask

  task automatic test_branch_priority();
    in_t s;
    obs_t e;
    for (int k = 0; k < 2; k++) begin
      s = '0;
      if (k == 0) begin s.pc = 1; s.resSrc = 2'b01; s.rdE = 7; s.rs1D = 7; end
      apply(s);
      sb.push_back(mk(2'b00, 2'b00, 5'b0, k == 0 ? 2'b11 : 2'b00, 1'b0));
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL branch_prio k=%0d got %h want %h", k, obs, e); end
      account(e, s.clr);
    end
  endtask

  task automatic test_mem_wait();
    in_t s;
    obs_t e;
    for (int k = 0; k < 7; k++) begin
      s = '0;
      s.req = (k <= 3 || k == 5);
      s.rdy = (k >= 3);
      s.pc = (k >= 1 && k <= 3);
      apply(s);
      sb.push_back(mk(2'b00, 2'b00, k <= 2 ? 5'b11111 : 5'b0, k == 3 ? 2'b11 : 2'b00, 1'b0));
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL mem_wait k=%0d got %h want %h", k, obs, e); end
      account(e, s.clr);
    end
  endtask

  task automatic test_timeout();
    in_t s;
    obs_t e;
    for (int k = 0; k < 11; k++) begin
      s = '0;
      s.req = (k != 8 && k != 10);
      s.rdy = (k == 8);
      apply(s);
      if (k == 9) begin reset = 1'b0; expSc = 0; expFc = 0; end
      if (k == 10) reset = 1'b1;
      sb.push_back(mk(2'b00, 2'b00, k <= 8 ? 5'b11111 : 5'b0, 2'b00, k >= 6 && k <= 8));
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL timeout k=%0d got %h want %h", k, obs, e); end
      account(e, s.clr);
    end
  endtask

  task automatic test_saturate();
    in_t s;
    obs_t e;
    for (int k = 0; k < 23; k++) begin
      s = '0;
      s.req = 1;
      s.clr = (k == 0 || k == 20);
      apply(s);
      sb.push_back(mk(2'b00, 2'b00, 5'b11111, 2'b00, k >= 6));
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL saturate k=%0d got %h want %h", k, obs, e); end
      account(e, s.clr);
    end
  endtask

  initial begin
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE} = '0;
    {RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM, CountClr} = '0;
    test_reset();
    test_forward();
    test_lw_stall();
    test_branch_priority();
    test_mem_wait();
    test_timeout();
    test_saturate();
    @(posedge clk);
    #1 reset = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
